// File: rtl/im_loadable.sv
// Loadable instruction memory: boot-time clear to FILL_INSTR, runtime load port,
// and a registered fetch port with stall, flush and out-of-range flagging.
module im_loadable #(
    parameter int                  INSTR_W    = 18,
    parameter int                  ADDR_W     = 8,
    parameter int                  DEPTH      = 8,
    parameter logic [INSTR_W-1:0]  FILL_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               ld_err,
    input  logic               fetch_en,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               addr_err,
    output logic               ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t              state_reg;
    logic [IDX_W-1:0]    init_cnt_reg;
    logic [INSTR_W-1:0]  mem [DEPTH];

    logic                ld_in_range;
    logic                pc_in_range;
    logic [IDX_W-1:0]    ld_idx;
    logic [IDX_W-1:0]    pc_idx;
    logic                ld_write;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [INSTR_W-1:0]  wr_data;
    logic [INSTR_W-1:0]  fetch_data;

    assign ld_in_range = {1'b0, ld_addr} < DEPTH_EXT;
    assign pc_in_range = {1'b0, pc} < DEPTH_EXT;
    assign ld_idx      = ld_addr[IDX_W-1:0];
    assign pc_idx      = pc[IDX_W-1:0];
    assign ld_write    = (state_reg == ST_READY) && ld_en && ld_in_range;

    // Single write port shared by the boot clear and the load port.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = init_cnt_reg;
        wr_data = FILL_INSTR;
        if (!reset) begin
            if (state_reg == ST_INIT) begin
                wr_en = 1'b1;
            end else if (ld_write) begin
                wr_en   = 1'b1;
                wr_idx  = ld_idx;
                wr_data = ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Write-through: a load to the address being fetched wins over the stale entry.
    assign fetch_data = (ld_write && (ld_addr == pc)) ? ld_data : mem[pc_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            instr        <= FILL_INSTR;
            instr_valid  <= 1'b0;
            addr_err     <= 1'b0;
            ld_err       <= 1'b0;
            ready        <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    init_cnt_reg <= init_cnt_reg + 1'b1;
                    if (init_cnt_reg == LAST_IDX) begin
                        state_reg <= ST_READY;
                        ready     <= 1'b1;
                    end
                end
                ST_READY: begin
                    ld_err <= ld_en && !ld_in_range;
                    if (flush) begin
                        instr       <= FILL_INSTR;
                        instr_valid <= 1'b0;
                        addr_err    <= 1'b0;
                    end else if (fetch_en) begin
                        instr_valid <= 1'b1;
                        if (pc_in_range) begin
                            instr    <= fetch_data;
                            addr_err <= 1'b0;
                        end else begin
                            instr    <= FILL_INSTR;
                            addr_err <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loadable.sv
// Bench for im_loadable: directed vector table, boot/reset sequences, and
// randomized traffic checked against an array-based reference model.
module tb_im_loadable;

    localparam int INSTR_W = 18;
    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 8;

    logic               clk;
    logic               reset;
    logic               ld_en;
    logic [ADDR_W-1:0]  ld_addr;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_err;
    logic               fetch_en;
    logic               flush;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               addr_err;
    logic               ready;

    int n_checks = 0;
    int n_pass   = 0;

    im_loadable #(
        .INSTR_W    (INSTR_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .FILL_INSTR ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_err      (ld_err),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .addr_err    (addr_err),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               ld_en;
        logic [ADDR_W-1:0]  ld_addr;
        logic [INSTR_W-1:0] ld_data;
        logic               fetch_en;
        logic               flush;
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] e_instr;
        logic               e_valid;
        logic               e_aerr;
        logic               e_lerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic le, input int la, input int ld,
                                input logic fe, input logic fl, input int p,
                                input int ei, input logic ev, input logic ea,
                                input logic el);
        vec_t v;
        v.ld_en = le;  v.ld_addr = ADDR_W'(la); v.ld_data = INSTR_W'(ld);
        v.fetch_en = fe; v.flush = fl; v.pc = ADDR_W'(p);
        v.e_instr = INSTR_W'(ei); v.e_valid = ev; v.e_aerr = ea; v.e_lerr = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic drive(input logic le, input int la, input int ld,
                         input logic fe, input logic fl, input int p);
        ld_en = le; ld_addr = ADDR_W'(la); ld_data = INSTR_W'(ld);
        fetch_en = fe; flush = fl; pc = ADDR_W'(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic boot_and_check(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
            chk({tag, "_lerr"}, 32'(ld_err), 32'd0);
            chk({tag, "_ready"}, 32'(ready), (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
    endtask

    // Reference model state
    logic [INSTR_W-1:0] m_mem [DEPTH];
    logic [INSTR_W-1:0] m_instr;
    logic               m_valid, m_aerr, m_lerr;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_aerr", 32'(addr_err), 32'd0);
        chk("rst_lerr", 32'(ld_err), 32'd0);

        // Boot with load/fetch attempts that must be ignored.
        reset = 1'b0;
        drive(1, 200, 18'h3FFFF, 1, 0, 0);
        boot_and_check("boot");
        $display("boot: ready=%0b after %0d edges", ready, DEPTH);

        for (int p = 0; p < DEPTH; p++)
            vecs.push_back(mk(0, 0, 0, 1, 0, p, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 'h19678, 0, 0, 0, 0, 1, 0, 0));       // load, stall
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 'h19678, 1, 0, 0));       // fetch loaded
        vecs.push_back(mk(1, 3, 'h36419, 1, 0, 3, 'h36419, 1, 0, 0)); // bypass
        vecs.push_back(mk(0, 0, 0, 1, 0, 8, 0, 1, 1, 0));             // pc == DEPTH
        vecs.push_back(mk(1, 200, 'h12345, 1, 0, 0, 0, 1, 0, 1));     // bad load
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));             // ld_err drops
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0));             // mem[0] untouched
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 'h19678, 1, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 3, 'h19678, 1, 0, 0));   // stall holds
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 0, 0));             // flush wins
        vecs.push_back(mk(0, 0, 0, 1, 0, 255, 0, 1, 1, 0));
        vecs.push_back(mk(1, 8, 'h1, 0, 1, 0, 0, 0, 0, 1));           // flush clears aerr
        vecs.push_back(mk(1, 7, 'h2BEEF, 1, 0, 3, 'h36419, 1, 0, 0)); // different addrs
        vecs.push_back(mk(0, 0, 0, 1, 0, 7, 'h2BEEF, 1, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].ld_en, int'(vecs[i].ld_addr), int'(vecs[i].ld_data),
                  vecs[i].fetch_en, vecs[i].flush, int'(vecs[i].pc));
            tick();
            chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vecs[i].e_instr));
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_aerr", i), 32'(addr_err), 32'(vecs[i].e_aerr));
            chk($sformatf("v%0d_lerr", i), 32'(ld_err), 32'(vecs[i].e_lerr));
            $display("vec %0d: pc=%0d ld=%0b@%0d instr=0x%0h v=%0b ae=%0b le=%0b",
                     i, vecs[i].pc, vecs[i].ld_en, vecs[i].ld_addr, instr,
                     instr_valid, addr_err, ld_err);
        end

        // Reset mid-run must restart the clear and wipe earlier loads.
        drive(1, 5, 'h2AAAA, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        reset = 1'b0;
        boot_and_check("reboot");
        drive(0, 0, 0, 1, 0, 5);
        tick();
        chk("reboot_pc5_instr", 32'(instr), 32'd0);
        chk("reboot_pc5_valid", 32'(instr_valid), 32'd1);
        $display("reboot: fetch pc=5 instr=0x%0h", instr);

        // Randomized traffic against the reference model.
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_instr = '0; m_valid = 1'b1; m_aerr = 1'b0;
        for (int t = 0; t < 400; t++) begin
            int la, p;
            la = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 9));
            p  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) p = la;
            drive(logic'($urandom_range(0, 1)), la, int'($urandom_range(0, 18'h3FFFF)),
                  logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 7) == 0), p);

            m_lerr = ld_en && (ld_addr >= DEPTH);
            if (flush) begin
                m_instr = '0; m_valid = 1'b0; m_aerr = 1'b0;
            end else if (fetch_en) begin
                m_valid = 1'b1;
                if (pc < DEPTH) begin
                    m_instr = (ld_en && ld_addr == pc) ? ld_data : m_mem[pc];
                    m_aerr  = 1'b0;
                end else begin
                    m_instr = '0; m_aerr = 1'b1;
                end
            end
            if (ld_en && ld_addr < DEPTH) m_mem[ld_addr] = ld_data;

            tick();
            chk($sformatf("r%0d_instr", t), 32'(instr), 32'(m_instr));
            chk($sformatf("r%0d_valid", t), 32'(instr_valid), 32'(m_valid));
            chk($sformatf("r%0d_aerr", t), 32'(addr_err), 32'(m_aerr));
            chk($sformatf("r%0d_lerr", t), 32'(ld_err), 32'(m_lerr));
            chk($sformatf("r%0d_ready", t), 32'(ready), 32'd1);
            $display("rnd %0d: ld=%0b@%0d fe=%0b fl=%0b pc=%0d instr=0x%0h v=%0b ae=%0b le=%0b",
                     t, ld_en, ld_addr, fetch_en, flush, pc, instr, instr_valid,
                     addr_err, ld_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/im_loadable.md
Name: im_loadable

Overview:
Parametrised instruction memory for the pipelined processor. It succeeds the fixed 8-entry reset-loaded instruction memory. The array is cleared to a fill word by a boot sequencer after reset, and is then written at runtime through a load port. The fetch stage reads it with a registered, stallable and flushable fetch port that flags out-of-range PCs.

Parameters:
INSTR_W, 18, instruction width ({opcode[1:0], op_a[7:0], op_b[7:0]} at default)
ADDR_W, 8, width of pc and ld_addr
DEPTH, 8, number of entries; legal range 2..2**ADDR_W
FILL_INSTR, 0, word written to every entry during boot and returned on out-of-range fetch or flush

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
ld_en  in  1  load-port write strobe
ld_addr  in  ADDR_W  load-port address
ld_data  in  INSTR_W  load-port data
ld_err  out  1  one-cycle pulse: load dropped (address out of range)
fetch_en  in  1  fetch enable; low = stall (hold output)
flush  in  1  kill current output instruction
pc  in  ADDR_W  fetch address
instr  out  INSTR_W  registered instruction
instr_valid  out  1  instr holds a valid fetched word
addr_err  out  1  instr came from an out-of-range pc
ready  out  1  boot clear complete; memory accepts loads and fetches

Behaviour:
- Reset (sampled at a clk edge with reset=1): state<=INIT, init_cnt<=0, instr<=FILL_INSTR, instr_valid<=0, addr_err<=0, ld_err<=0, ready<=0. Array contents are not reset directly. Reset mid-boot or mid-operation restarts INIT.
- FSM states INIT and READY.
- INIT:
  - Each edge writes mem[init_cnt]<=FILL_INSTR and increments init_cnt.
  - On the edge that writes entry DEPTH-1, the FSM goes to READY and ready<=1. ready is therefore high exactly DEPTH edges after the first edge with reset=0.
  - ld_en, fetch_en and flush are ignored. Outputs stay at their reset values, and ld_err stays 0.
- READY, load port:
  - ld_en=1 and ld_addr<DEPTH: mem[ld_addr]<=ld_data.
  - ld_en=1 and ld_addr>=DEPTH: no write, ld_err=1 on the next cycle only.
- READY, fetch port (1-cycle latency):
  - Priority is flush > fetch_en > stall.
  - flush=1: instr<=FILL_INSTR, instr_valid<=0, addr_err<=0.
  - fetch_en=1 and pc<DEPTH: instr<=mem[pc], instr_valid<=1, addr_err<=0.
  - fetch_en=1 and pc>=DEPTH: instr<=FILL_INSTR, instr_valid<=1, addr_err<=1.
  - fetch_en=0 and flush=0: instr, instr_valid and addr_err hold.
- Same-cycle load and fetch to the same in-range address: write-through bypass, so instr<=ld_data in that cycle. Different addresses are fully independent.
- Out-of-range comparison is on the full ADDR_W value. There is no address wrap.
- ready stays 1 until the next reset.

Test Plan:
- Reset 1 cycle, then run DEPTH=8 edges -> ready rises after the 8th edge; during INIT a fetch_en/ld_en attempt leaves instr_valid=0, ld_err=0. Then fetch pc=0..7 -> instr=0, instr_valid=1.
- Load addr 1 with 0x19678 ({1,150,120}), next cycle fetch pc=1 -> instr=0x19678, instr_valid=1, addr_err=0.
- Same cycle: ld_addr=3, ld_data=0x36419 ({3,100,25}), fetch pc=3 -> instr=0x36419 on the next cycle (bypass).
- Fetch pc=8 (DEPTH=8) -> instr=FILL_INSTR, instr_valid=1, addr_err=1. Load ld_addr=200 -> ld_err high for exactly 1 cycle, and a fetch of pc=0 still returns 0.
- With valid instr=0x19678: fetch_en=0 for 3 cycles -> instr held. flush=1 together with fetch_en=1 -> instr=FILL_INSTR, instr_valid=0.
- Load addr 5, then assert reset mid-run -> ready=0, INIT restarts, and after 8 edges a fetch of pc=5 returns FILL_INSTR.
